// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage register with a 2-entry skid buffer,
// synchronous flush, run gating and a saturating back-pressure counter.
module pipe_stage_skid #(
   parameter int unsigned DATA_W      = 32,
   parameter bit          ZERO_BUBBLE = 1'b1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  bp_cnt_o
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               full_q, full_d;
   logic [DATA_W-1:0]  main_q, main_d;
   logic [DATA_W-1:0]  skid_q, skid_d;
   logic [CNT_W-1:0]   bp_q, bp_d;
   logic               in_fire, out_fire, stall;

   assign in_ready_o  = start_i & ~full_q;
   assign out_valid_o = (state_q != S_EMPTY);
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = out_valid_o & out_ready_i;
   assign stall       = out_valid_o & ~out_ready_i;

   // Bubbles read as zero so a dead slot carries no write enables
   assign out_data_o  = (out_valid_o || !ZERO_BUBBLE) ? main_q : '0;
   assign occupancy_o = state_q;
   assign bp_cnt_o    = bp_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = S_EMPTY;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (in_fire) begin
                  state_d = S_ONE;
                  main_d  = in_data_i;
               end
            end
            S_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data_i;
               end else if (in_fire) begin
                  state_d = S_TWO;
                  skid_d  = in_data_i;
               end else if (out_fire) begin
                  state_d = S_EMPTY;
               end
            end
            S_TWO: begin
               if (out_fire) begin
                  state_d = S_ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
      full_d = (state_d == S_TWO);
   end

   always_comb begin
      bp_d = bp_q;
      if (stall && (bp_q != '1)) begin
         bp_d = bp_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_EMPTY;
         full_q  <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
         bp_q    <= '0;
      end else begin
         state_q <= state_d;
         full_q  <= full_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         bp_q    <= bp_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: queue model checked every cycle
// plus literal expectations at key points of each scenario.
module tb_pipe_stage_skid;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       start_i = 1'b0;
   logic       flush_i = 1'b0;
   logic       in_valid_i = 1'b0;
   logic       in_ready_o;
   logic [7:0] in_data_i = '0;
   logic       out_valid_o;
   logic       out_ready_i = 1'b0;
   logic [7:0] out_data_o;
   logic [1:0] occupancy_o;
   logic [2:0] bp_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mq[$];
   int         mbp = 0;
   logic [7:0] got[$];

   pipe_stage_skid #(
      .DATA_W(8),
      .ZERO_BUBBLE(1'b1),
      .CNT_W(3)
   ) dut (
      .clk_i(clk_i),
      .rst_n_i(rst_n_i),
      .start_i(start_i),
      .flush_i(flush_i),
      .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o),
      .in_data_i(in_data_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_data_o(out_data_o),
      .occupancy_o(occupancy_o),
      .bp_cnt_o(bp_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge rst_n_i) begin
      mq.delete();
      mbp = 0;
   end

   // Model: a FIFO of at most two entries, advanced on each rising edge
   always @(posedge clk_i) begin
      bit ifire, ofire;
      if (out_valid_o && out_ready_i) got.push_back(out_data_o);
      if (!rst_n_i) begin
         mq.delete();
         mbp = 0;
      end else begin
         ifire = in_valid_i && start_i && (mq.size() < 2);
         ofire = (mq.size() > 0) && out_ready_i;
         if ((mq.size() > 0) && !out_ready_i && mbp < 7) mbp++;
         if (flush_i) begin
            mq.delete();
         end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(in_data_i);
         end
      end
      #1;
      chk("valid", 32'(out_valid_o), 32'(mq.size() > 0));
      chk("data", 32'(out_data_o), 32'((mq.size() > 0) ? mq[0] : 8'h00));
      chk("occ", 32'(occupancy_o), 32'(mq.size()));
      chk("ready", 32'(in_ready_o), 32'(start_i && (mq.size() < 2)));
      chk("bp", 32'(bp_cnt_o), 32'(mbp));
   end

   task automatic drive(input logic st, input logic iv, input logic [7:0] d,
                        input logic ordy, input logic fl);
      @(negedge clk_i);
      start_i     = st;
      in_valid_i  = iv;
      in_data_i   = d;
      out_ready_i = ordy;
      flush_i     = fl;
   endtask

   task automatic settle();
      @(posedge clk_i);
      #2;
   endtask

   initial begin
      logic [7:0] exp8;
      start_i = 1'b1;
      #2;
      chk("rst_valid", 32'(out_valid_o), 32'd0);
      chk("rst_data", 32'(out_data_o), 32'd0);
      chk("rst_occ", 32'(occupancy_o), 32'd0);
      chk("rst_bp", 32'(bp_cnt_o), 32'd0);
      chk("rst_ready", 32'(in_ready_o), 32'd1);
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;

      // 1: streaming at full rate
      got.delete();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 1'b1, 8'(i), 1'b1, 1'b0);
         settle();
         chk("s1_occ", 32'(occupancy_o), 32'd1);
         chk("s1_head", 32'(out_data_o), 32'(i));
      end
      drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      settle();
      chk("s1_cnt", 32'(got.size()), 32'd8);
      for (int i = 0; i < 8 && i < got.size(); i++)
         chk("s1_order", 32'(got[i]), 32'(i + 1));
      chk("s1_bp", 32'(bp_cnt_o), 32'd0);

      // 2: skid fill and release
      got.delete();
      drive(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
      settle();
      chk("s2_occ1", 32'(occupancy_o), 32'd1);
      drive(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
      settle();
      chk("s2_occ2", 32'(occupancy_o), 32'd2);
      chk("s2_rdy0", 32'(in_ready_o), 32'd0);
      chk("s2_head", 32'(out_data_o), 32'hA1);
      drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      settle();
      chk("s2_rdy1", 32'(in_ready_o), 32'd1);
      chk("s2_headB", 32'(out_data_o), 32'hB2);
      settle();
      chk("s2_cnt", 32'(got.size()), 32'd2);
      if (got.size() == 2) begin
         chk("s2_A", 32'(got[0]), 32'hA1);
         chk("s2_B", 32'(got[1]), 32'hB2);
      end

      // 3: flush colliding with accept and deliver
      got.delete();
      drive(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 8'hC3, 1'b1, 1'b1);
      settle();
      chk("s3_valid", 32'(out_valid_o), 32'd0);
      chk("s3_data", 32'(out_data_o), 32'd0);
      chk("s3_occ", 32'(occupancy_o), 32'd0);
      drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      repeat (3) settle();
      chk("s3_cnt", 32'(got.size()), 32'd1);
      if (got.size() > 0) chk("s3_A", 32'(got[0]), 32'hC1);

      // 4: start gating; held entries still drain
      got.delete();
      drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
      repeat (3) settle();
      chk("s4_rdy", 32'(in_ready_o), 32'd0);
      chk("s4_occ", 32'(occupancy_o), 32'd0);
      drive(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
      repeat (2) settle();
      chk("s4_drain", 32'(occupancy_o), 32'd0);
      chk("s4_cnt", 32'(got.size()), 32'd1);
      if (got.size() > 0) chk("s4_val", 32'(got[0]), 32'h66);

      // 5: counter saturation
      drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (10) settle();
      chk("s5_bp", 32'(bp_cnt_o), 32'd7);

      // 6: async reset with two entries held
      drive(1'b1, 1'b1, 8'h88, 1'b0, 1'b0);
      settle();
      chk("s6_occ2", 32'(occupancy_o), 32'd2);
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      rst_n_i = 1'b0;
      #1;
      chk("s6_valid", 32'(out_valid_o), 32'd0);
      chk("s6_occ", 32'(occupancy_o), 32'd0);
      chk("s6_bp", 32'(bp_cnt_o), 32'd0);
      exp8 = 8'h00;
      chk("s6_data", 32'(out_data_o), 32'(exp8));
      @(negedge clk_i);
      rst_n_i = 1'b1;
      drive(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
      settle();
      chk("s6_after", 32'(out_data_o), 32'h99);
      drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      repeat (2) settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
